m68k_bus_arbiter: RTL and testbench
===================================

// Module: m68k_bus_arbiter
// PURPOSE
//  Owns 68K bus mastership for the PiStorm CPLD. Sits between the Pi bus-cycle engine
//  (S0..S7 sequencer) and the 68K BR_n/BG_n/BGACK_n lines. Blocks new engine cycles when an
//  external master requests the bus, issues BG_n after the current cycle ends, tristates
//  our bus drivers while the external master owns the bus, and reclaims the bus afterwards.
// PARAMETERS
//  SYNC_STAGES     2   flops on BR_n/BGACK_n/M68K_CLK before use (c7m uses SYNC_STAGES+1 for edge)
//  RECLAIM_CYCLES  2   c7m falling edges with drivers still off after external master releases
//  BG_TIMEOUT      16  c7m falling edges in GRANT with no BGACK_n before BG is withdrawn
//  HOLDOFF_CYCLES  8   c7m falling edges of guaranteed engine ownership (ARB_HOLDOFF_EN only)
// PORTS
//  PI_CLK        in   1  200 MHz clock; sole clock of the block
//  PI_RST        in   1  synchronous reset, active-high
//  M68K_CLK      in   1  raw 7 MHz 68K clock, sampled as data
//  M68K_BR_n     in   1  bus request from external master, async
//  M68K_BGACK_n  in   1  bus grant acknowledge, async
//  M68K_AS_n     in   1  our engine's AS_n output, fed back
//  OP_REQ        in   1  engine has a pending Pi transaction
//  OP_ACTIVE     in   1  engine is in S1..S7 (not S0/Sr)
//  OP_GRANT      out  1  engine may leave S0/Sr to start a cycle
//  M68K_BG_n     out  1  bus grant to 68K bus
//  BUS_OE_n      out  1  1 = tristate AS/UDS/LDS/RW/FC/address-latch drivers
//  EXT_OWNER     out  1  1 while state is GRANT or EXT (readable via REG_STATUS)
//  ARB_STATE     out  3  state encoding for debug/status readback
// BEHAVIOUR
//  Reset (PI_RST=1 at PI_CLK edge, any state): M68K_BG_n=1, OP_GRANT=1, BUS_OE_n=0,
//   EXT_OWNER=0, ARB_STATE=OWN, counters=0; effective next PI_CLK edge.
//  br_s/bgack_s = synchronized active-high BR/BGACK; c7m_fall = 1-PI_CLK pulse on sync'd M68K_CLK 1->0.
//  All outputs registered. State moves only on c7m_fall except OWN->PEND (any PI_CLK edge).
//  States (ARB_STATE): OWN=0 PEND=1 GRANT=2 EXT=3 RECLAIM=4 HOLDOFF=5.
//  OWN: br_s=1 -> PEND, OP_GRANT=0 on same edge (1 PI_CLK latency after br_s).
//  PEND: br_s=0 -> OWN, OP_GRANT=1. Else on c7m_fall with OP_ACTIVE=0 and AS_n=1 -> GRANT,
//   M68K_BG_n=0 and BUS_OE_n=1 on same edge. An engine cycle already started (OP_ACTIVE=1 when
//   br_s rose) always completes; BG never asserts while AS_n=0.
//  GRANT: on c7m_fall: bgack_s=1 -> EXT, BG_n=1. br_s=0 and bgack_s=0 on two consecutive
//   c7m_fall -> RECLAIM, BG_n=1 (master withdrew). BG_TIMEOUT c7m_fall without bgack -> RECLAIM.
//  EXT: on c7m_fall with bgack_s=0: br_s=1 -> GRANT (BG_n=0, second master); else -> RECLAIM.
//  RECLAIM: counts RECLAIM_CYCLES c7m_fall, BUS_OE_n stays 1; at terminal count BUS_OE_n=0,
//   OP_GRANT=1, next state OWN (or HOLDOFF with macro). br_s during RECLAIM is remembered
//   as level only: still high at exit -> OWN then PEND next PI_CLK.
//  Counters saturate; 5-bit counter width covers all defaults; params must be >=1.
//  OP_REQ is status-only (no effect on arbitration; engine gates itself on OP_GRANT).
//  Illegal ARB_STATE values (6,7) -> OWN next PI_CLK with reset output values.
// CONFIGURATION
//  PISTORM_ARB_HOLDOFF_EN defined: RECLAIM -> HOLDOFF; BR ignored for HOLDOFF_CYCLES c7m_fall
//   (OP_GRANT=1), then OWN; guarantees Pi forward progress under continuous BR.
//  Undefined: HOLDOFF state and counter absent; RECLAIM -> OWN; BR honoured immediately.
// STRUCTURE
//  Package pistorm_arb_pkg: state enum/encodings, ARB_STATE width, counter width constant.
//  Sub-module m68k_sync_edge: N-stage synchronizer with rise/fall pulse outputs; three
//   instances (M68K_CLK, M68K_BR_n, M68K_BGACK_n). FSM and counters stay in the top.
// TESTING
//  Idle bus, BR_n low 3 c7m, BGACK_n low, BR_n high, BGACK_n low 20 c7m then high ->
//   states 0,1,2,3,4,0; BG_n low exactly from PEND exit to first c7m_fall with BGACK; BUS_OE_n=1 throughout.
//  BR_n falls while OP_ACTIVE=1, AS_n=0 -> OP_GRANT=0 in 1+SYNC_STAGES PI_CLK, BG_n stays 1
//   until first c7m_fall after AS_n=1 and OP_ACTIVE=0.
//  BR_n pulses low 1 c7m then high, no BGACK -> PEND->OWN, BG_n never 0; or if GRANT reached,
//   BG_n=1 after 2 c7m_fall, RECLAIM 2 c7m_fall, OWN.
//  BR_n held low, BGACK_n never -> BG_n=0 for 16 c7m_fall, RECLAIM; without macro re-enters
//   PEND immediately; with PISTORM_ARB_HOLDOFF_EN OP_GRANT=1 for 8 c7m_fall first.
//  BGACK_n high while BR_n still low (second master) -> EXT->GRANT, BG_n=0, BUS_OE_n stays 1.
//  PI_RST pulse in EXT -> next PI_CLK: BG_n=1, BUS_OE_n=0, OP_GRANT=1, ARB_STATE=0.

Source files
------------

// File: rtl/pistorm_arb_pkg.sv
// ---------------------------------------------------------------------------
// pistorm_arb_pkg
//   Shared definitions for the PiStorm 68K bus arbiter:
//     - ARB_STATE_W : width of the debug/status state field
//     - CNT_W       : width of the arbiter's cycle counter (covers all defaults)
//     - arb_state_e : arbiter state encodings as exposed on ARB_STATE
//     - arb_out_t   : bundle of the registered bus-control outputs
//     - state_outputs() : output values owned by each state
//     - sat_inc()   : saturating counter increment
// ---------------------------------------------------------------------------
package pistorm_arb_pkg;

  localparam int ARB_STATE_W = 3;
  localparam int CNT_W       = 5;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_OWN     = 3'd0,
    ST_PEND    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_EXT     = 3'd3,
    ST_RECLAIM = 3'd4,
    ST_HOLDOFF = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic bg_n;
    logic oe_n;
    logic op_grant;
    logic ext_owner;
  } arb_out_t;

  // Output values while sitting in a given state. Anything unknown falls back
  // to the reset values (engine owns the bus, no grant).
  function automatic arb_out_t state_outputs(input arb_state_e s);
    arb_out_t o;
    o.bg_n      = 1'b1;
    o.oe_n      = 1'b0;
    o.op_grant  = 1'b1;
    o.ext_owner = 1'b0;
    case (s)
      ST_PEND: begin
        o.op_grant = 1'b0;
      end
      ST_GRANT: begin
        o.bg_n      = 1'b0;
        o.oe_n      = 1'b1;
        o.op_grant  = 1'b0;
        o.ext_owner = 1'b1;
      end
      ST_EXT: begin
        o.oe_n      = 1'b1;
        o.op_grant  = 1'b0;
        o.ext_owner = 1'b1;
      end
      ST_RECLAIM: begin
        o.oe_n     = 1'b1;
        o.op_grant = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/m68k_sync_edge.sv
// ---------------------------------------------------------------------------
// m68k_sync_edge
//   STAGES-flop synchronizer for an asynchronous single-bit input, followed by
//   one history flop used for edge detection (STAGES+1 flops in total).
//   Ports:
//     clk   in  sampling clock
//     rst   in  synchronous active-high reset (chain loads RESET_VAL)
//     din   in  asynchronous input
//     level out synchronized level of din
//     rise  out one-clk pulse on synchronized 0->1
//     fall  out one-clk pulse on synchronized 1->0
// ---------------------------------------------------------------------------
module m68k_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_p[STAGES-1:0] is the metastability chain, sync_p[STAGES] holds the
  // previous synchronized level for edge detection.
  logic [STAGES:0] sync_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= {(STAGES+1){RESET_VAL}};
    end else begin
      sync_p <= {sync_p[STAGES-1:0], din};
    end
  end

  assign level = sync_p[STAGES-1];
  assign rise  = sync_p[STAGES-1] & ~sync_p[STAGES];
  assign fall  = ~sync_p[STAGES-1] & sync_p[STAGES];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// ---------------------------------------------------------------------------
// m68k_bus_arbiter
//   Owns 68K bus mastership for the PiStorm CPLD. Stops the Pi bus-cycle
//   engine from starting new cycles when an external master requests the bus,
//   grants the bus once the current cycle has finished, keeps our drivers
//   tristated while the external master owns the bus, and reclaims it after.
//
//   Optional feature: define PISTORM_ARB_HOLDOFF_EN to insert a HOLDOFF state
//   after RECLAIM that ignores BR for HOLDOFF_CYCLES 7 MHz periods, so the Pi
//   keeps making progress under a continuous bus request.
//
//   Ports:
//     PI_CLK        in   200 MHz clock, sole clock of the block
//     PI_RST        in   synchronous active-high reset
//     M68K_CLK      in   raw 7 MHz 68K clock, sampled as data
//     M68K_BR_n     in   bus request from external master (async)
//     M68K_BGACK_n  in   bus grant acknowledge (async)
//     M68K_AS_n     in   our engine's AS_n, fed back
//     OP_REQ        in   engine has a pending Pi transaction (status only)
//     OP_ACTIVE     in   engine is in S1..S7
//     OP_GRANT      out  engine may leave S0/Sr to start a cycle
//     M68K_BG_n     out  bus grant to the 68K bus
//     BUS_OE_n      out  1 = tristate AS/UDS/LDS/RW/FC/address-latch drivers
//     EXT_OWNER     out  1 while in GRANT or EXT
//     ARB_STATE     out  state encoding for debug/status readback
// ---------------------------------------------------------------------------
module m68k_bus_arbiter
  import pistorm_arb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RECLAIM_CYCLES = 2,
  parameter int BG_TIMEOUT     = 16,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic                   PI_CLK,
  input  logic                   PI_RST,
  input  logic                   M68K_CLK,
  input  logic                   M68K_BR_n,
  input  logic                   M68K_BGACK_n,
  input  logic                   M68K_AS_n,
  input  logic                   OP_REQ,
  input  logic                   OP_ACTIVE,
  output logic                   OP_GRANT,
  output logic                   M68K_BG_n,
  output logic                   BUS_OE_n,
  output logic                   EXT_OWNER,
  output logic [ARB_STATE_W-1:0] ARB_STATE
);

  localparam logic [CNT_W-1:0] BG_TC      = CNT_W'(BG_TIMEOUT);
  localparam logic [CNT_W-1:0] RECLAIM_TC = CNT_W'(RECLAIM_CYCLES);
  localparam logic [CNT_W-1:0] HOLDOFF_TC = CNT_W'(HOLDOFF_CYCLES);

  logic br_lvl_n, br_rise, br_fall;
  logic bgack_lvl_n, bgack_rise, bgack_fall;
  logic c7m_lvl, c7m_rise, c7m_fall;
  logic br_s, bgack_s;

  m68k_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
    .clk   (PI_CLK),
    .rst   (PI_RST),
    .din   (M68K_BR_n),
    .level (br_lvl_n),
    .rise  (br_rise),
    .fall  (br_fall)
  );

  m68k_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
    .clk   (PI_CLK),
    .rst   (PI_RST),
    .din   (M68K_BGACK_n),
    .level (bgack_lvl_n),
    .rise  (bgack_rise),
    .fall  (bgack_fall)
  );

  // Reset value 0 means a high M68K_CLK after reset reads as a rise, never
  // as a spurious falling edge.
  m68k_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_c7m (
    .clk   (PI_CLK),
    .rst   (PI_RST),
    .din   (M68K_CLK),
    .level (c7m_lvl),
    .rise  (c7m_rise),
    .fall  (c7m_fall)
  );

  assign br_s    = ~br_lvl_n;
  assign bgack_s = ~bgack_lvl_n;

  // Edge pulses of BR/BGACK, the c7m level and OP_REQ are not needed by the
  // arbitration decision; collect them here so they are visibly intentional.
  logic arb_unused;
`ifdef PISTORM_ARB_HOLDOFF_EN
  assign arb_unused = ^{OP_REQ, br_rise, br_fall, bgack_rise, bgack_fall,
                        c7m_rise, c7m_lvl};
`else
  assign arb_unused = ^{OP_REQ, br_rise, br_fall, bgack_rise, bgack_fall,
                        c7m_rise, c7m_lvl, HOLDOFF_TC};
`endif

  arb_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             quiet, quiet_nx;
  arb_out_t         outs_nx;

  // ---- state / output register stage ----
  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      state     <= ST_OWN;
      cnt       <= '0;
      quiet     <= 1'b0;
      M68K_BG_n <= 1'b1;
      BUS_OE_n  <= 1'b0;
      OP_GRANT  <= 1'b1;
      EXT_OWNER <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      quiet     <= quiet_nx;
      M68K_BG_n <= outs_nx.bg_n;
      BUS_OE_n  <= outs_nx.oe_n;
      OP_GRANT  <= outs_nx.op_grant;
      EXT_OWNER <= outs_nx.ext_owner;
    end
  end

  assign ARB_STATE = state;

  // ---- next-state decode ----
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    quiet_nx = quiet;
    cnt_inc  = sat_inc(cnt);

    case (state)
      ST_OWN: begin
        if (br_s) state_nx = ST_PEND;
      end

      // An engine cycle already in flight always completes: grant only on a
      // 7 MHz falling edge with the engine idle and AS_n negated.
      ST_PEND: begin
        if (c7m_fall) begin
          if (!br_s)                          state_nx = ST_OWN;
          else if (!OP_ACTIVE && M68K_AS_n)   state_nx = ST_GRANT;
        end
      end

      // cnt counts 7 MHz falls without BGACK; quiet remembers that the previous
      // fall saw neither BR nor BGACK (master gave up before acknowledging).
      ST_GRANT: begin
        if (c7m_fall) begin
          cnt_nx   = cnt_inc;
          quiet_nx = ~br_s & ~bgack_s;
          if (bgack_s)                  state_nx = ST_EXT;
          else if (!br_s && quiet)      state_nx = ST_RECLAIM;
          else if (cnt_inc >= BG_TC)    state_nx = ST_RECLAIM;
        end
      end

      // BR still asserted when BGACK drops means a second master is waiting.
      ST_EXT: begin
        if (c7m_fall && !bgack_s) state_nx = br_s ? ST_GRANT : ST_RECLAIM;
      end

      ST_RECLAIM: begin
        if (c7m_fall) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= RECLAIM_TC) begin
`ifdef PISTORM_ARB_HOLDOFF_EN
            state_nx = ST_HOLDOFF;
`else
            state_nx = ST_OWN;
`endif
          end
        end
      end

`ifdef PISTORM_ARB_HOLDOFF_EN
      ST_HOLDOFF: begin
        if (c7m_fall) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= HOLDOFF_TC) state_nx = ST_OWN;
        end
      end
`endif

      default: state_nx = ST_OWN;
    endcase

    // Every state starts its own count from zero.
    if (state_nx != state) begin
      cnt_nx   = '0;
      quiet_nx = 1'b0;
    end

    outs_nx = state_outputs(state_nx);
  end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_arbiter
//   Directed scenarios followed by randomized bus activity. Every PI_CLK edge
//   the DUT outputs are compared with a reference model that tracks bus
//   ownership from the arbitration rules, with the input synchronizers modelled
//   as plain delay lines.
// ---------------------------------------------------------------------------
module tb_m68k_bus_arbiter;

  localparam int S   = 2;   // SYNC_STAGES
  localparam int RC  = 2;   // RECLAIM_CYCLES
  localparam int TO  = 16;  // BG_TIMEOUT
  localparam int HO  = 8;   // HOLDOFF_CYCLES
  localparam int C7P = 8;   // PI_CLK periods per M68K_CLK period in this bench

  localparam int M_OWN = 0, M_PEND = 1, M_GRANT = 2, M_EXT = 3,
                 M_RECLAIM = 4, M_HOLDOFF = 5;

  logic       PI_CLK = 1'b0;
  logic       PI_RST, M68K_CLK, M68K_BR_n, M68K_BGACK_n, M68K_AS_n;
  logic       OP_REQ, OP_ACTIVE;
  logic       OP_GRANT, M68K_BG_n, BUS_OE_n, EXT_OWNER;
  logic [2:0] ARB_STATE;

  m68k_bus_arbiter #(
    .SYNC_STAGES(S), .RECLAIM_CYCLES(RC), .BG_TIMEOUT(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .PI_CLK       (PI_CLK),
    .PI_RST       (PI_RST),
    .M68K_CLK     (M68K_CLK),
    .M68K_BR_n    (M68K_BR_n),
    .M68K_BGACK_n (M68K_BGACK_n),
    .M68K_AS_n    (M68K_AS_n),
    .OP_REQ       (OP_REQ),
    .OP_ACTIVE    (OP_ACTIVE),
    .OP_GRANT     (OP_GRANT),
    .M68K_BG_n    (M68K_BG_n),
    .BUS_OE_n     (BUS_OE_n),
    .EXT_OWNER    (EXT_OWNER),
    .ARB_STATE    (ARB_STATE)
  );

  always #5 PI_CLK = ~PI_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int c7_phase = 0;

  // Reference model: who owns the bus, plus delay lines for the synchronizers.
  logic [S-1:0] m_br_q    = '0;  // active-high request history
  logic [S-1:0] m_bgack_q = '0;  // active-high acknowledge history
  logic [S:0]   m_clk_q   = '0;
  int m_state = M_OWN;
  int m_falls = 0;   // 7 MHz falls seen in the current phase
  int m_quiet = 0;   // consecutive falls in GRANT with neither BR nor BGACK

  int seen[$];
  logic [2:0] last_state = 3'd0;

  function automatic void model_edge();
    bit br, bgack, fall;
    int nxt;
    br    = m_br_q[S-1];
    bgack = m_bgack_q[S-1];
    fall  = m_clk_q[S] & ~m_clk_q[S-1];
    if (PI_RST) begin
      m_state = M_OWN; m_falls = 0; m_quiet = 0;
    end else begin
      nxt = m_state;
      if (m_state == M_OWN) begin
        if (br) nxt = M_PEND;
      end else if (fall) begin
        if (m_state == M_PEND) begin
          if (!br) nxt = M_OWN;
          else if (!OP_ACTIVE && M68K_AS_n) nxt = M_GRANT;
        end else if (m_state == M_GRANT) begin
          m_falls++;
          m_quiet = (!br && !bgack) ? m_quiet + 1 : 0;
          if (bgack) nxt = M_EXT;
          else if (m_quiet >= 2) nxt = M_RECLAIM;
          else if (m_falls >= TO) nxt = M_RECLAIM;
        end else if (m_state == M_EXT) begin
          if (!bgack) nxt = br ? M_GRANT : M_RECLAIM;
        end else if (m_state == M_RECLAIM) begin
          m_falls++;
`ifdef PISTORM_ARB_HOLDOFF_EN
          if (m_falls >= RC) nxt = M_HOLDOFF;
`else
          if (m_falls >= RC) nxt = M_OWN;
`endif
        end else if (m_state == M_HOLDOFF) begin
          m_falls++;
          if (m_falls >= HO) nxt = M_OWN;
        end
      end
      if (nxt != m_state) begin m_falls = 0; m_quiet = 0; end
      m_state = nxt;
    end
    m_br_q    = {m_br_q[S-2:0], ~M68K_BR_n};
    m_bgack_q = {m_bgack_q[S-2:0], ~M68K_BGACK_n};
    m_clk_q   = {m_clk_q[S-1:0], M68K_CLK};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One PI_CLK edge: advance M68K_CLK at the falling edge, update the model
  // at the rising edge, compare just after it.
  task automatic step();
    @(negedge PI_CLK);
    c7_phase = (c7_phase + 1) % C7P;
    M68K_CLK = (c7_phase < C7P/2);
    @(posedge PI_CLK);
    model_edge();
    #1;
    chk("arb_state", 8'(ARB_STATE), 8'(m_state));
    chk("bg_n",      8'(M68K_BG_n), 8'(m_state != M_GRANT));
    chk("bus_oe_n",  8'(BUS_OE_n),
        8'(m_state == M_GRANT || m_state == M_EXT || m_state == M_RECLAIM));
    chk("op_grant",  8'(OP_GRANT),  8'(m_state == M_OWN || m_state == M_HOLDOFF));
    chk("ext_owner", 8'(EXT_OWNER), 8'(m_state == M_GRANT || m_state == M_EXT));
    if (ARB_STATE !== last_state) begin
      seen.push_back(int'(ARB_STATE));
      last_state = ARB_STATE;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_bg(input string tag, input int budget);
    int n;
    n = 0;
    while (M68K_BG_n !== 1'b0 && n < budget) begin step(); n++; end
    chk(tag, 8'(M68K_BG_n), 8'd0);
  endtask

  task automatic clear_seen();
    seen.delete();
    seen.push_back(int'(ARB_STATE));
    last_state = ARB_STATE;
  endtask

  initial begin
    int n;
    int exp_a[6];
    exp_a = '{0, 1, 2, 3, 4, 0};

    PI_RST = 1'b1; M68K_CLK = 1'b1; M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1;
    M68K_AS_n = 1'b1; OP_REQ = 1'b0; OP_ACTIVE = 1'b0;

    // Reset state
    step();
    chk("rst_bg_n", 8'(M68K_BG_n), 8'd1);
    chk("rst_oe_n", 8'(BUS_OE_n), 8'd0);
    chk("rst_op_grant", 8'(OP_GRANT), 8'd1);
    chk("rst_state", 8'(ARB_STATE), 8'd0);
    steps(6);
    PI_RST = 1'b0;
    steps(12);

    // A: full handover, then release
    clear_seen();
    M68K_BR_n = 1'b0;
    wait_bg("a_wait_bg", 60);
    steps(2*C7P);
    M68K_BGACK_n = 1'b0;
    steps(C7P);
    M68K_BR_n = 1'b1;
    steps(20*C7P);
    M68K_BGACK_n = 1'b1;
    steps(10*C7P);
    chk("a_nstates", 8'(seen.size()), 8'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      chk("a_state_seq", 8'(seen[i]), 8'(exp_a[i]));

    // B: request while an engine cycle is in flight
    OP_ACTIVE = 1'b1; M68K_AS_n = 1'b0; OP_REQ = 1'b1;
    steps(3);
    M68K_BR_n = 1'b0;
    n = 0;
    while (OP_GRANT !== 1'b0 && n < 20) begin step(); n++; end
    chk("b_grant_latency", 8'(n), 8'(1 + S));
    steps(5*C7P);
    chk("b_bg_held", 8'(M68K_BG_n), 8'd1);
    M68K_AS_n = 1'b1; OP_ACTIVE = 1'b0; OP_REQ = 1'b0;
    wait_bg("b_wait_bg", 40);
    M68K_BR_n = 1'b1;
    steps(8*C7P);
    chk("b_back_own", 8'(ARB_STATE), 8'd0);

    // C: short BR pulse without BGACK
    M68K_BR_n = 1'b0;
    steps(C7P);
    M68K_BR_n = 1'b1;
    steps(8*C7P);
    chk("c_back_own", 8'(ARB_STATE), 8'd0);

    // D: BR held, BGACK never comes -> timeout
    M68K_BR_n = 1'b0;
    wait_bg("d_wait_bg", 60);
    n = 0;
    while (M68K_BG_n === 1'b0 && n < 400) begin step(); n++; end
    chk("d_bg_low_len", 8'(n), 8'(TO*C7P));
    steps(RC*C7P + 4);
`ifdef PISTORM_ARB_HOLDOFF_EN
    chk("d_after_reclaim", 8'(ARB_STATE), 8'(M_HOLDOFF));
`else
    chk("d_after_reclaim", 8'(ARB_STATE), 8'(M_PEND));
`endif
    M68K_BR_n = 1'b1;
    steps(15*C7P);

    // E: second master waiting when the first releases BGACK
    M68K_BR_n = 1'b0;
    wait_bg("e_wait_bg", 60);
    M68K_BGACK_n = 1'b0;
    steps(3*C7P);
    M68K_BGACK_n = 1'b1;
    wait_bg("e_regrant", 40);
    chk("e_oe_n", 8'(BUS_OE_n), 8'd1);
    M68K_BGACK_n = 1'b0;
    steps(2*C7P);
    M68K_BR_n = 1'b1;
    steps(2*C7P);
    M68K_BGACK_n = 1'b1;
    steps(8*C7P);

    // F: reset while an external master owns the bus
    M68K_BR_n = 1'b0;
    wait_bg("f_wait_bg", 60);
    M68K_BGACK_n = 1'b0;
    steps(3*C7P);
    chk("f_in_ext", 8'(ARB_STATE), 8'(M_EXT));
    PI_RST = 1'b1;
    step();
    chk("f_rst_bg_n", 8'(M68K_BG_n), 8'd1);
    chk("f_rst_oe_n", 8'(BUS_OE_n), 8'd0);
    chk("f_rst_op_grant", 8'(OP_GRANT), 8'd1);
    chk("f_rst_state", 8'(ARB_STATE), 8'd0);
    M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1;
    steps(6);
    PI_RST = 1'b0;
    steps(12);

    // R: randomized bus activity
    for (int k = 0; k < 120; k++) begin
      int len;
      len = $urandom_range(1, 48);
      M68K_BR_n    = 1'($urandom_range(0, 1));
      M68K_BGACK_n = ($urandom_range(0, 3) != 0);
      OP_ACTIVE    = 1'($urandom_range(0, 1));
      M68K_AS_n    = OP_ACTIVE ? 1'($urandom_range(0, 1)) : 1'b1;
      OP_REQ       = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        if (M68K_BG_n === 1'b0 && $urandom_range(0, 7) == 0) M68K_BGACK_n = 1'b0;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
